// File: rtl/opfetch_pkg.sv
// opfetch_pkg: shared constants and types for the decode-stage operand reader.
// Holds operand/address widths, the $0 register number and the bypass-select enum.
package opfetch_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        SEL_EX,
        SEL_MEM,
        SEL_WB,
        SEL_RF
    } bypass_sel_t;

endpackage

// File: rtl/opfetch_bypass_mux.sv
// opfetch_bypass_mux: per-operand producer match and operand select.
// Ports: src/src_use (operand), rf_rdata, EX/MEM/WB producer views, data + hazard out.
// Option: OPFETCH_BYPASS_EN selects forwarding; undefined -> stall on any match.
module opfetch_bypass_mux
    import opfetch_pkg::*;
#(
    parameter int DATA_W = opfetch_pkg::DATA_W,
    parameter int REG_AW = opfetch_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_use,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_wdest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_wdest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_wdest,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] data,
    output logic              hazard
);

    // $0 is hard-wired, so a read of it never depends on a producer
    logic live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign live    = src_use && (src != REG_AW'(REG_ZERO));
    assign ex_hit  = live && ex_valid && (ex_wdest == src);
    assign mem_hit = live && mem_valid && (mem_wdest == src);
    assign wb_hit  = live && wb_valid && (wb_wdest == src);

`ifdef OPFETCH_BYPASS_EN
    bypass_sel_t sel;

    // Youngest producer wins when several stages write the same register
    always_comb begin
        sel = SEL_RF;
        if (ex_hit)
            sel = SEL_EX;
        else if (mem_hit)
            sel = SEL_MEM;
        else if (wb_hit)
            sel = SEL_WB;
    end

    always_comb begin
        data = rf_rdata;
        unique case (sel)
            SEL_EX:  data = ex_result;
            SEL_MEM: data = mem_result;
            SEL_WB:  data = wb_wdata;
            SEL_RF:  data = rf_rdata;
        endcase
    end

    // Load data only exists once the load reaches MEM
    assign hazard = ex_hit && ex_is_load;
`else
    logic unused_bypass;

    assign unused_bypass = ^{ex_result, mem_result, wb_wdata, ex_is_load};
    assign data          = rf_rdata;
    assign hazard        = ex_hit || mem_hit || wb_hit;
`endif

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads rs/rt, resolves RAW hazards by bypass or interlock, holds ID/EX.
// Ports: IF/ID handshake + sources, register file read port, EX/MEM/WB producers,
// ID/EX outputs, stall_cnt. Option: OPFETCH_BYPASS_EN enables forwarding.
module operand_fetch
    import opfetch_pkg::*;
#(
    parameter int DATA_W = opfetch_pkg::DATA_W,
    parameter int REG_AW = opfetch_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_wdest,
    input  logic              id_is_load,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_wdest,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_wdest,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              ex_allowin,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_src1,
    output logic [DATA_W-1:0] ex_src2,
    output logic [REG_AW-1:0] ex_wdest,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              haz1;
    logic              haz2;
    logic              stall;

    assign rf_raddr1 = id_rs;
    assign rf_raddr2 = id_rt;

    opfetch_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux1 (
        .src        (id_rs),
        .src_use    (id_use_rs),
        .rf_rdata   (rf_rdata1),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_wdest   (ex_wdest),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_wdest  (mem_wdest),
        .mem_result (mem_result),
        .wb_valid   (wb_valid),
        .wb_wdest   (wb_wdest),
        .wb_wdata   (wb_wdata),
        .data       (src1),
        .hazard     (haz1)
    );

    opfetch_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux2 (
        .src        (id_rt),
        .src_use    (id_use_rt),
        .rf_rdata   (rf_rdata2),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_wdest   (ex_wdest),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_wdest  (mem_wdest),
        .mem_result (mem_result),
        .wb_valid   (wb_valid),
        .wb_wdest   (wb_wdest),
        .wb_wdata   (wb_wdata),
        .data       (src2),
        .hazard     (haz2)
    );

    assign stall = id_valid && (haz1 || haz2);

    // Nothing is accepted while reset holds the pipeline register clear
    assign id_ready = resetn && id_valid && !stall && (!ex_valid || ex_allowin);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ex_valid   <= 1'b0;
            ex_src1    <= '0;
            ex_src2    <= '0;
            ex_wdest   <= '0;
            ex_is_load <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (id_ready) begin
                ex_valid   <= 1'b1;
                ex_src1    <= src1;
                ex_src2    <= src2;
                ex_wdest   <= id_wdest;
                ex_is_load <= id_is_load;
            end else if (ex_allowin) begin
                ex_valid <= 1'b0;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed table plus hazard sequences for operand_fetch.
// Expectations follow OPFETCH_BYPASS_EN when the bench is built with it.
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_wdest;
    logic          id_is_load;
    logic [AW-1:0] rf_raddr1;
    logic [AW-1:0] rf_raddr2;
    logic [DW-1:0] rf_rdata1;
    logic [DW-1:0] rf_rdata2;
    logic [DW-1:0] ex_result;
    logic          mem_valid;
    logic [AW-1:0] mem_wdest;
    logic [DW-1:0] mem_result;
    logic          wb_valid;
    logic [AW-1:0] wb_wdest;
    logic [DW-1:0] wb_wdata;
    logic          ex_allowin;
    logic          ex_valid;
    logic [DW-1:0] ex_src1;
    logic [DW-1:0] ex_src2;
    logic [AW-1:0] ex_wdest;
    logic          ex_is_load;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wdest   (id_wdest),
        .id_is_load (id_is_load),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_wdest  (mem_wdest),
        .mem_result (mem_result),
        .wb_valid   (wb_valid),
        .wb_wdest   (wb_wdest),
        .wb_wdata   (wb_wdata),
        .ex_allowin (ex_allowin),
        .ex_valid   (ex_valid),
        .ex_src1    (ex_src1),
        .ex_src2    (ex_src2),
        .ex_wdest   (ex_wdest),
        .ex_is_load (ex_is_load),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic          v;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          urs;
        logic          urt;
        logic [4:0]    wd;
        logic          ld;
        logic [31:0]   rf1;
        logic [31:0]   rf2;
        logic          mv;
        logic [4:0]    mwd;
        logic          wv;
        logic [4:0]    wwd;
        logic          alw;
        logic          rdy;
        logic          ev;
        logic [31:0]   s1;
        logic [31:0]   s2;
        logic [4:0]    ewd;
    } vec_t;

    vec_t        tbl[10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_scnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_rdy(input string nm, input logic exp);
        #1;
        chk({nm, ".rdy"}, 32'(id_ready), 32'(exp));
        tick();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] wd,
                          input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wdest   = wd;
        id_is_load = ld;
    endtask

    task automatic set_prod(input logic mv, input logic [4:0] mwd,
                            input logic [31:0] mres, input logic wv,
                            input logic [4:0] wwd, input logic [31:0] wdat);
        mem_valid  = mv;
        mem_wdest  = mwd;
        mem_result = mres;
        wb_valid   = wv;
        wb_wdest   = wwd;
        wb_wdata   = wdat;
    endtask

    initial begin
        // v rs rt urs urt wd ld rf1 rf2 mv mwd wv wwd alw | rdy ev s1 s2 ewd
        tbl[0] = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0,
                   32'hA1, 32'hB2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1,
                   1'b1, 1'b1, 32'hA1, 32'hB2, 5'd0};
        tbl[1] = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0,
                   32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1,
                   1'b1, 1'b1, 32'h0, 32'h0, 5'd4};
        tbl[2] = '{1'b1, 5'd9, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0,
                   32'h99, 32'hAA, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1,
                   1'b1, 1'b1, 32'h99, 32'hAA, 5'd0};
        tbl[3] = '{1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd6, 1'b0,
                   32'h11B, 32'h12C, 1'b0, 5'd11, 1'b0, 5'd12, 1'b1,
                   1'b1, 1'b1, 32'h11B, 32'h12C, 5'd6};
        tbl[4] = '{1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0,
                   32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                   1'b0, 1'b1, 32'h11B, 32'h12C, 5'd6};
        tbl[5] = tbl[4];
        tbl[6] = tbl[4];
        tbl[7] = '{1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0,
                   32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1,
                   1'b0, 1'b0, 32'h11B, 32'h12C, 5'd6};
        tbl[8] = '{1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0,
                   32'h1, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                   1'b0, 1'b0, 32'h11B, 32'h12C, 5'd6};
        tbl[9] = '{1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0,
                   32'h61, 32'h62, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0,
                   1'b1, 1'b1, 32'h61, 32'h62, 5'd0};

        // Reset held two cycles with a valid instruction waiting
        resetn = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1  = 32'h0;
        rf_rdata2  = 32'h0;
        ex_result  = 32'h0;
        ex_allowin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            chk("rst.rdy", 32'(id_ready), 32'h0);
        end
        chk("rst.ev", 32'(ex_valid), 32'h0);
        chk("rst.cnt", stall_cnt, 32'h0);
        chk("rst.src1", ex_src1, 32'h0);
        chk("rst.wd", 32'(ex_wdest), 32'h0);
        resetn = 1'b1;

        // Table: no live producer hazards, identical in both builds
        ex_result = 32'h55;
        exp_scnt  = 32'h0;
        for (int i = 0; i < 10; i++) begin
            set_id(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs,
                   tbl[i].urt, tbl[i].wd, tbl[i].ld);
            set_prod(tbl[i].mv, tbl[i].mwd, 32'h66,
                     tbl[i].wv, tbl[i].wwd, 32'h77);
            rf_rdata1  = tbl[i].rf1;
            rf_rdata2  = tbl[i].rf2;
            ex_allowin = tbl[i].alw;
            step_rdy($sformatf("t%0d", i), tbl[i].rdy);
            chk($sformatf("t%0d.ev", i), 32'(ex_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d.s1", i), ex_src1, tbl[i].s1);
            chk($sformatf("t%0d.s2", i), ex_src2, tbl[i].s2);
            chk($sformatf("t%0d.wd", i), 32'(ex_wdest), 32'(tbl[i].ewd));
            chk($sformatf("t%0d.cnt", i), stall_cnt, exp_scnt);
        end

        // A: addu $3 then back-to-back use of $3
        ex_allowin = 1'b1;
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h0;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
        step_rdy("A.addu", 1'b1);
        set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
        rf_rdata1 = 32'hBAD;
        rf_rdata2 = 32'h22;
        ex_result = 32'h11;
`ifdef OPFETCH_BYPASS_EN
        step_rdy("A.use", 1'b1);
`else
        step_rdy("A.ex", 1'b0);
        chk("A.bubble", 32'(ex_valid), 32'h0);
        set_prod(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        step_rdy("A.mem", 1'b0);
        set_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
        step_rdy("A.wb", 1'b0);
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'h11;
        step_rdy("A.rf", 1'b1);
        exp_scnt = exp_scnt + 32'd3;
`endif
        chk("A.ev", 32'(ex_valid), 32'h1);
        chk("A.s1", ex_src1, 32'h11);
        chk("A.s2", ex_src2, 32'h22);
        chk("A.cnt", stall_cnt, exp_scnt);

        // B: lw $5 then addu reading $5: one bubble at least
        rf_rdata1 = 32'h1;
        rf_rdata2 = 32'h0;
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1);
        step_rdy("B.lw", 1'b1);
        chk("B.ld", 32'(ex_is_load), 32'h1);
        chk("B.wd", 32'(ex_wdest), 32'h5);
        set_id(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0);
        rf_rdata1 = 32'h44;
        ex_result = 32'hBAD0;
        step_rdy("B.ex", 1'b0);
        exp_scnt = exp_scnt + 32'd1;
        chk("B.bubble", 32'(ex_valid), 32'h0);
        chk("B.cnt1", stall_cnt, exp_scnt);
        set_prod(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
`ifdef OPFETCH_BYPASS_EN
        step_rdy("B.mem", 1'b1);
`else
        step_rdy("B.mem", 1'b0);
        set_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        step_rdy("B.wb", 1'b0);
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata2 = 32'hDEADBEEF;
        step_rdy("B.rf", 1'b1);
        exp_scnt = exp_scnt + 32'd2;
`endif
        chk("B.ev", 32'(ex_valid), 32'h1);
        chk("B.s1", ex_src1, 32'h44);
        chk("B.s2", ex_src2, 32'hDEADBEEF);
        chk("B.ld2", 32'(ex_is_load), 32'h0);
        chk("B.cnt", stall_cnt, exp_scnt);

        // C: WB producer $7 while the register file still reads stale 0
        set_prod(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h1;
        set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
`ifdef OPFETCH_BYPASS_EN
        step_rdy("C.wb", 1'b1);
`else
        step_rdy("C.wb", 1'b0);
        exp_scnt = exp_scnt + 32'd1;
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'h7;
        step_rdy("C.rf", 1'b1);
`endif
        chk("C.s1", ex_src1, 32'h7);
        chk("C.s2", ex_src2, 32'h1);
        chk("C.cnt", stall_cnt, exp_scnt);

        // D: $13 in EX, MEM and WB, both operands read it
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'h1;
        rf_rdata2 = 32'h2;
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b0);
        step_rdy("D.prod", 1'b1);
        set_id(1'b1, 5'd13, 5'd13, 1'b1, 1'b1, 5'd0, 1'b0);
        ex_result = 32'hE1;
        set_prod(1'b1, 5'd13, 32'hA1, 1'b1, 5'd13, 32'hB1);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h0;
`ifdef OPFETCH_BYPASS_EN
        step_rdy("D.all", 1'b1);
`else
        step_rdy("D.all", 1'b0);
        exp_scnt = exp_scnt + 32'd1;
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'hE1;
        rf_rdata2 = 32'hE1;
        step_rdy("D.rf", 1'b1);
`endif
        chk("D.s1", ex_src1, 32'hE1);
        chk("D.s2", ex_src2, 32'hE1);

        // D2: $13 only in MEM and WB, MEM must win
        set_prod(1'b1, 5'd13, 32'hA1, 1'b1, 5'd13, 32'hB1);
        rf_rdata1 = 32'h0;
        rf_rdata2 = 32'h0;
`ifdef OPFETCH_BYPASS_EN
        step_rdy("D2.mw", 1'b1);
`else
        step_rdy("D2.mw", 1'b0);
        exp_scnt = exp_scnt + 32'd1;
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rf_rdata1 = 32'hA1;
        rf_rdata2 = 32'hA1;
        step_rdy("D2.rf", 1'b1);
`endif
        chk("D2.s1", ex_src1, 32'hA1);
        chk("D2.s2", ex_src2, 32'hA1);
        chk("D2.cnt", stall_cnt, exp_scnt);

        // E: reset during a load-use stall clears ID/EX and the counter
        set_prod(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1);
        step_rdy("E.lw", 1'b1);
        set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        step_rdy("E.use", 1'b0);
        resetn = 1'b0;
        step_rdy("E.rst", 1'b0);
        chk("E.ev", 32'(ex_valid), 32'h0);
        chk("E.s1", ex_src1, 32'h0);
        chk("E.wd", 32'(ex_wdest), 32'h0);
        chk("E.ld", 32'(ex_is_load), 32'h0);
        chk("E.cnt", stall_cnt, 32'h0);
        resetn    = 1'b1;
        rf_rdata1 = 32'h66;
        step_rdy("E.replay", 1'b1);
        chk("E.ev2", 32'(ex_valid), 32'h1);
        chk("E.s1b", ex_src1, 32'h66);
        chk("E.cnt2", stall_cnt, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-stage operand reader for the 5-stage pipeline: drives the register file's two read addresses, resolves RAW hazards against in-flight EX/MEM/WB producers by bypass or interlock, and holds the ID/EX pipeline register. It sits between the IF/ID register and the EX stage, and is the read-side counterpart of the register file's write port.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- CNT_W, 32, stall counter width
- clk  in  1  clock; everything updates on posedge
- resetn  in  1  reset, synchronous, active-low
- id_valid  in  1  IF/ID holds a valid instruction
- id_ready  out  1  instruction accepted this cycle
- id_rs, id_rt  in  REG_AW  source register numbers
- id_use_rs, id_use_rt  in  1  source actually read
- id_wdest  in  REG_AW  destination (0 = no write)
- id_is_load  in  1  instruction is a load
- rf_raddr1, rf_raddr2  out  REG_AW  register file read addresses (= id_rs, id_rt, combinational)
- rf_rdata1, rf_rdata2  in  DATA_W  register file read data (combinational, $0 reads 0)
- ex_result  in  DATA_W  EX-stage ALU result of the instruction in the ID/EX register
- mem_valid, mem_wdest, mem_result  in  1/REG_AW/DATA_W  MEM-stage producer
- wb_valid, wb_wdest, wb_wdata  in  1/REG_AW/DATA_W  WB-stage producer (same values driven into register file write port)
- ex_allowin  in  1  EX accepts ID/EX contents this cycle
- ex_valid  out  1  ID/EX register valid
- ex_src1, ex_src2  out  DATA_W  resolved operands
- ex_wdest  out  REG_AW  registered destination
- ex_is_load  out  1  registered load flag
- stall_cnt  out  CNT_W  cycles lost to hazard stalls

## Operation
- Producer match: stage valid, wdest != 0, wdest == source, source used. $0 never matches.
- EX producer: the internal ID/EX register (ex_valid, ex_wdest, ex_is_load).
- Bypass priority per operand: EX (ex_result) > MEM > WB > rf_rdata. WB bypass is mandatory: register file write lands at the same edge as capture.
- Load-use hazard: EX producer match with ex_is_load=1 → stall.
- stall = id_valid & hazard; id_ready = id_valid & !stall & (!ex_valid | ex_allowin).
- ID/EX update: id_ready → load operands, wdest, is_load, ex_valid=1; else ex_allowin → ex_valid=0 (bubble); else hold.
- stall_cnt increments when stall=1, saturates at all-ones.

## Timing
- Reset: ex_valid=0, ex_src1/2=0, ex_wdest=0, ex_is_load=0, stall_cnt=0. Reset mid-stall drops the stalled instruction's ID/EX state; IF/ID replays.
- Accept-to-EX latency: 1 cycle.
- Load-use costs exactly 1 bubble; next cycle the load is in MEM and mem_result is bypassed.
- ex_allowin=0 with no hazard: id_ready=0, ID/EX holds, stall_cnt unchanged (back-pressure, not hazard).
- Both operands name the same register: both take the same bypass source.
- Same register in EX, MEM and WB: EX wins.

## Configuration
- OPFETCH_BYPASS_EN defined: bypass network as above.
- Undefined: no forwarding; hazard = any EX/MEM/WB producer match; operands come only from rf_rdata. WB match still stalls 1 cycle. ex_result/mem_result/wb_wdata unused.

## Structure
- Package opfetch_pkg: DATA_W, REG_AW, REG_ZERO constant, bypass-select enum (SEL_EX, SEL_MEM, SEL_WB, SEL_RF).
- Sub-module opfetch_bypass_mux: one instance per operand; match logic and priority select.

## Test plan
- Reset held 2 cycles with id_valid=1 → ex_valid=0, stall_cnt=0, id_ready=0.
- addu $3 (ex_result=0x11) then use $3 back-to-back → ex_src1=0x11, no stall (bypass on); 3 stall cycles with bypass off.
- lw $5 then addu using $5, mem_result=0xDEADBEEF → one bubble (ex_valid=0), stall_cnt=1, then ex_src2=0xDEADBEEF.
- wb_wdest=$7, wb_wdata=0x7 while rf_rdata1=0 stale → ex_src1=0x7.
- Producer wdest=$0, ex_result=0x55, consumer reads $0 → ex_src1=0, no stall.
- ex_allowin=0 for 3 cycles, no hazard → ID/EX held, id_ready=0, stall_cnt unchanged.
